sct_count_sequencer: RTL
========================

// Module: sct_count_sequencer
// PURPOSE
//  Sequencer for the SCT g..n count-chain datapath. Holds the CNT_W-bit down-count
//  register and accepts LOAD/START/STOP/ABORT commands over a valid/ready port.
//  Counts prescaled ticks, qualified by the enable (g0) and hold (q) terms.
//  Raises a terminal-count event on a valid/ready done port, with optional auto-reload.
// PARAMETERS
//  CNT_W     8  width of count and reload registers
//  PRESC_W   4  width of prescale divider counter
//  PRESCALE  0  ticks per decrement minus 1 (0 = decrement every qualified tick)
// PORTS
//  clk_pad         in   1      single clock, all state on rising edge
//  rst_n_pad       in   1      asynchronous, active-low reset
//  cmd_valid_pad   in   1      command present
//  cmd_ready_pad   out  1      command accepted when valid&ready
//  cmd_op_pad      in   2      00 ABORT, 01 LOAD, 10 START, 11 STOP
//  cmd_data_pad    in   CNT_W  LOAD value; loaded into both cnt and reload registers
//  reload_en_pad   in   1      sampled at START; 1 = auto-reload on terminal count
//  tick_en_pad     in   1      count enable (g0 term)
//  hold_pad        in   1      freeze count while 1 (q term)
//  cnt_pad         out  CNT_W  current count register
//  busy_pad        out  1      1 in RUN
//  tc_pad          out  1      one-cycle pulse on terminal count
//  done_valid_pad  out  1      terminal-count event pending
//  done_ready_pad  in   1      consumer accepts done event
//  ovr_pad         out  1      sticky: tc occurred while done_valid already pending
// BEHAVIOUR
//  Reset: state IDLE; cnt, reload, prescale count = 0; all outputs 0 except cmd_ready=1.
//  qualified tick q_t = tick_en & ~hold & (state==RUN).
//  prescaler counts q_t; step = q_t & (presc==PRESCALE); presc wraps to 0 on step;
//   presc cleared on START, STOP, ABORT; it holds while q_t=0.
//  FSM states: IDLE, LOADED, RUN, DONE.
//  IDLE/LOADED: cmd_ready=1 for every op.
//   LOAD  -> cnt=reload=data; ovr cleared; state LOADED.
//   START -> latch reload_en; state RUN (from IDLE, runs from current cnt).
//   STOP  -> no-op. ABORT -> cnt=0; state IDLE.
//  RUN: cmd_ready=1 only for STOP/ABORT; LOAD/START are stalled (ready=0).
//   step & cnt!=0 -> cnt-1 next cycle.
//   step & cnt==0 -> tc_pad=1 in the same cycle (combinational from registered state).
//    Done event: done_valid set next cycle; if done_valid is already pending, ovr=1.
//    reload latched -> cnt=reload and stay RUN; else go to DONE.
//   STOP  -> LOADED; cnt retained. ABORT -> IDLE; cnt=0.
//   accepted STOP/ABORT in the same cycle as a terminal step: command wins, no tc.
//  DONE: cmd_ready=1 only for ABORT. done_valid&done_ready -> IDLE, cnt holds 0.
//  done port: done_valid held until done_ready; clears on handshake or ABORT.
//   Handshake and a new tc in the same cycle: done_valid stays 1; ovr not set.
//  latency: command takes effect the cycle after acceptance; first decrement at
//   earliest one cycle after START. tc pulse is exactly one cycle.
//  arithmetic: unsigned; no underflow past 0; START with cnt=0 gives tc on first step.
//  reset mid-operation: immediate return to reset values; no tc or done emitted.
// STRUCTURE
//  package sct_ctrl_pkg: op_e (ABORT, LOAD, START, STOP), state_e (IDLE, LOADED, RUN, DONE),
//   CNT_W_DEF, PRESC_W_DEF constants.
//  sub-module sct_prescaler (PRESC_W, PRESCALE; in: q_t, clr; out: step).
//  top contains the FSM, the count/reload registers and the done/ovr logic.
// TESTING
//  1. reset mid-RUN with cnt=5 -> next cycle cnt=0, IDLE, tc=0, done_valid=0, cmd_ready=1.
//  2. LOAD 3, START reload_en=0, tick_en=1, hold=0, PRESCALE=0:
//     cnt 3,2,1,0 -> tc pulses 4 cycles after START is registered; DONE; done_valid=1.
//     done_ready=1 -> IDLE.
//  3. LOAD 2, START reload_en=1, done_ready=0: first tc -> cnt=2, done_valid=1;
//     second tc -> ovr=1, state stays RUN.
//  4. hold=1 for 3 cycles mid-count with cnt=4 -> cnt frozen at 4, presc frozen;
//     resumes on hold=0.
//  5. PRESCALE=3: LOAD 1 -> cnt decrements once every 4 qualified ticks; tc after 8 ticks.
//  6. STOP issued in the tc cycle with cnt=0 -> LOADED, tc=0, done_valid=0;
//     LOAD during RUN -> cmd_ready=0 until STOP.

Source files
------------

// File: rtl/sct_ctrl_pkg.sv
// sct_ctrl_pkg: shared command/state encodings and default widths for the SCT count sequencer
package sct_ctrl_pkg;
    typedef enum logic [1:0] {ABORT = 2'b00, LOAD = 2'b01, START = 2'b10, STOP = 2'b11} op_e;
    typedef enum logic [1:0] {IDLE, LOADED, RUN, DONE} state_e;
    localparam int CNT_W_DEF = 8;
    localparam int PRESC_W_DEF = 4;
endpackage

// File: rtl/sct_prescaler.sv
// sct_prescaler: divides qualified ticks into count steps every PRESCALE+1 ticks
module sct_prescaler
    import sct_ctrl_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int PRESCALE = 0
) (
    input  logic clk_pad,
    input  logic rst_n_pad,
    input  logic q_t_i,
    input  logic clr_i,
    output logic step_o
);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE);
    logic [PRESC_W-1:0] presc_q, presc_d;
    always_comb begin
        step_o  = q_t_i && (presc_q == PRESC_MAX);
        presc_d = (clr_i || step_o) ? '0 : q_t_i ? presc_q + 1'b1 : presc_q;
    end
    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) presc_q <= '0;
        else presc_q <= presc_d;
    end
endmodule

// File: rtl/sct_count_sequencer.sv
// sct_count_sequencer: command-driven down-counter with prescaled ticks, terminal-count event and auto-reload
module sct_count_sequencer
    import sct_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int PRESCALE = 0
) (
    input  logic             clk_pad,
    input  logic             rst_n_pad,
    input  logic             cmd_valid_pad,
    output logic             cmd_ready_pad,
    input  logic [1:0]       cmd_op_pad,
    input  logic [CNT_W-1:0] cmd_data_pad,
    input  logic             reload_en_pad,
    input  logic             tick_en_pad,
    input  logic             hold_pad,
    output logic [CNT_W-1:0] cnt_pad,
    output logic             busy_pad,
    output logic             tc_pad,
    output logic             done_valid_pad,
    input  logic             done_ready_pad,
    output logic             ovr_pad
);
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, reload_q, reload_d;
    logic rel_en_q, rel_en_d, done_valid_q, done_valid_d, ovr_q, ovr_d;
    logic accept, q_t, step;
    op_e op;
    assign op = op_e'(cmd_op_pad);
    always_comb begin
        cmd_ready_pad = (state_q == RUN) ? (op == STOP || op == ABORT) :
                        (state_q == DONE) ? (op == ABORT) : 1'b1;
        accept = cmd_valid_pad && cmd_ready_pad;
        q_t    = tick_en_pad && !hold_pad && (state_q == RUN);
        // an accepted STOP/ABORT pre-empts a terminal step in the same cycle
        tc_pad = (state_q == RUN) && step && (cnt_q == '0) && !accept;
    end
    sct_prescaler #(.PRESC_W(PRESC_W), .PRESCALE(PRESCALE)) u_presc (
        .clk_pad  (clk_pad),
        .rst_n_pad(rst_n_pad),
        .q_t_i    (q_t),
        .clr_i    (accept && op != LOAD),
        .step_o   (step)
    );
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        rel_en_d = rel_en_q;
        if (accept && op == ABORT) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, LOADED: begin
                    if (accept && op == LOAD) begin
                        cnt_d    = cmd_data_pad;
                        reload_d = cmd_data_pad;
                        state_d  = LOADED;
                    end else if (accept && op == START) begin
                        rel_en_d = reload_en_pad;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (accept) state_d = LOADED;
                    else if (step && cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    else if (step && rel_en_q) cnt_d = reload_q;
                    else if (step) state_d = DONE;
                end
                DONE: state_d = (done_valid_q && done_ready_pad) ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
        done_valid_d = (accept && op == ABORT) ? 1'b0 : tc_pad || (done_valid_q && !done_ready_pad);
        ovr_d        = (accept && op == LOAD) ? 1'b0 : ovr_q || (tc_pad && done_valid_q && !done_ready_pad);
    end
    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            reload_q     <= '0;
            rel_en_q     <= 1'b0;
            done_valid_q <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reload_q     <= reload_d;
            rel_en_q     <= rel_en_d;
            done_valid_q <= done_valid_d;
            ovr_q        <= ovr_d;
        end
    end
    assign cnt_pad        = cnt_q;
    assign busy_pad       = (state_q == RUN);
    assign done_valid_pad = done_valid_q;
    assign ovr_pad        = ovr_q;
endmodule
